// File: rtl/uart_tx_param.sv
// Purpose : UART transmit engine with a built-in Tx FIFO, compensated bit-period
//           generator, optional parity, selectable bit order and 1/2 stop bits.
// Latency : a frame starts (LOAD) the 2nd cycle after a push into an idle engine;
//           Tx_o falls the cycle after LOAD; p_SendFinished_o pulses the cycle
//           after the last stop-bit clock.
// Backpr. : no ready handshake; pushes while full are dropped and set p_Over_o.
// Ports   : clk/rst (async active-low); Data_i/n_We_i/n_Clr_i FIFO side;
//           Divisor_i/RoundUpNum_i/RoundDownNum_i baud; p_ParityEnable_i,
//           ParityMethod_i, p_BigEnd_i, StopBits_i frame format (sampled in LOAD);
//           FIFO status p_Full_o/p_NearFull_o/p_Empty_o/p_Over_o/Level_o;
//           p_Busy_o, p_SendFinished_o, Tx_o line side.
// Option  : define UART_TX_BREAK_EN to add p_Break_i (hold Tx_o low while idle).
module uart_tx_param #(
  parameter int DATA_W      = 8,
  parameter int FIFO_AW     = 4,
  parameter int NEARFULL_TH = 12,
  parameter int DIV_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_Enable_i,
  input  logic [DATA_W-1:0] Data_i,
  input  logic              n_We_i,
  input  logic              n_Clr_i,
  input  logic [DIV_W-1:0]  Divisor_i,
  input  logic [3:0]        RoundUpNum_i,
  input  logic [3:0]        RoundDownNum_i,
  input  logic              p_ParityEnable_i,
  input  logic              ParityMethod_i,
  input  logic              p_BigEnd_i,
  input  logic              StopBits_i,
`ifdef UART_TX_BREAK_EN
  input  logic              p_Break_i,
`endif
  output logic              p_Full_o,
  output logic              p_NearFull_o,
  output logic              p_Empty_o,
  output logic              p_Over_o,
  output logic [FIFO_AW:0]  Level_o,
  output logic              p_Busy_o,
  output logic              p_SendFinished_o,
  output logic              Tx_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] NF_LVL   = (FIFO_AW + 1)'(NEARFULL_TH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic brk;
`ifdef UART_TX_BREAK_EN
  assign brk = p_Break_i;
`else
  assign brk = 1'b0;
`endif

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               over_q;
  logic               full, empty, push, pop;
  logic [DATA_W-1:0]  rd_word;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  // A flush discards any write in the same cycle.
  assign push    = !n_We_i && !full && n_Clr_i;
  assign rd_word = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= Data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      over_q   <= 1'b0;
    end else if (!n_Clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      over_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW + 1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW + 1)'(1);
        default: level_q <= level_q;
      endcase
      if (!n_We_i && full) over_q <= 1'b1;
    end
  end

  // ---------------- Frame engine ----------------
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d, big_q, big_d, par_en_q, par_en_d;
  logic              two_q, two_d, stop2_q, stop2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        up_q, up_d, dn_q, dn_d, idx_q, idx_d;
  logic [4:0]        pos_q, pos_d, pos_nxt, pat_len;
  logic [DIV_W:0]    cnt_q, cnt_d, bit_len;
  logic              tx_q, tx_d, fin_q, fin_d;
  logic              in_bit, bit_end, start_ok;
  logic [DATA_W-1:0] sh_r, sh_l;

  // The first U positions of each U+D pattern get one extra clock.
  assign bit_len  = {1'b0, div_q} + {{DIV_W{1'b0}}, (pos_q < {1'b0, up_q})};
  assign bit_end  = (cnt_q == bit_len);   // cnt runs 1..bit_len
  assign pat_len  = {1'b0, up_q} + {1'b0, dn_q};
  assign pos_nxt  = ((pos_q + 5'd1) >= pat_len) ? 5'd0 : pos_q + 5'd1;
  assign in_bit   = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
  assign start_ok = p_Enable_i && !empty && !brk;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    big_d    = big_q;
    par_en_d = par_en_q;
    two_d    = two_q;
    div_d    = div_q;
    up_d     = up_q;
    dn_d     = dn_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stop2_d  = stop2_q;
    fin_d    = 1'b0;
    pop      = 1'b0;

    if (in_bit) begin
      if (bit_end) begin
        cnt_d = (DIV_W + 1)'(1);
        pos_d = pos_nxt;
      end else begin
        cnt_d = cnt_q + (DIV_W + 1)'(1);
      end
    end

    case (state_q)
      S_IDLE: if (start_ok) state_d = S_LOAD;
      S_LOAD: begin
        // A flush between IDLE and LOAD can empty the FIFO under us.
        if (empty) begin
          state_d = S_IDLE;
        end else begin
          pop      = 1'b1;
          data_d   = rd_word;
          par_d    = (^rd_word) ^ ParityMethod_i;
          big_d    = p_BigEnd_i;
          par_en_d = p_ParityEnable_i;
          two_d    = StopBits_i;
          div_d    = (Divisor_i < DIV_W'(2)) ? DIV_W'(2) : Divisor_i;
          up_d     = RoundUpNum_i;
          dn_d     = RoundDownNum_i;
          pos_d    = '0;
          cnt_d    = (DIV_W + 1)'(1);
          idx_d    = '0;
          stop2_d  = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 4'(DATA_W - 1)) state_d = par_en_q ? S_PARITY : S_STOP;
          else                         idx_d   = idx_q + 4'd1;
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            fin_d   = 1'b1;
            // Go straight to LOAD so back-to-back frames have no idle gap.
            state_d = start_ok ? S_LOAD : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    sh_r = data_d >> idx_d;
    sh_l = data_d << idx_d;
    case (state_d)
      S_IDLE:   tx_d = ~brk;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = big_d ? sh_l[DATA_W-1] : sh_r[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      big_q    <= 1'b0;
      par_en_q <= 1'b0;
      two_q    <= 1'b0;
      div_q    <= DIV_W'(2);
      up_q     <= '0;
      dn_q     <= '0;
      pos_q    <= '0;
      cnt_q    <= (DIV_W + 1)'(1);
      idx_q    <= '0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      big_q    <= big_d;
      par_en_q <= par_en_d;
      two_q    <= two_d;
      div_q    <= div_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      fin_q    <= fin_d;
    end
  end

  assign p_Full_o         = full;
  assign p_NearFull_o     = (level_q >= NF_LVL);
  assign p_Empty_o        = empty;
  assign p_Over_o         = over_q;
  assign Level_o          = level_q;
  assign p_Busy_o         = (state_q != S_IDLE);
  assign p_SendFinished_o = fin_q;
  assign Tx_o             = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param (default parameters). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_uart_tx_param;

  logic        clk;
  logic        rst;
  logic        p_Enable_i;
  logic [7:0]  Data_i;
  logic        n_We_i;
  logic        n_Clr_i;
  logic [11:0] Divisor_i;
  logic [3:0]  RoundUpNum_i;
  logic [3:0]  RoundDownNum_i;
  logic        p_ParityEnable_i;
  logic        ParityMethod_i;
  logic        p_BigEnd_i;
  logic        StopBits_i;
`ifdef UART_TX_BREAK_EN
  logic        p_Break_i;
`endif
  logic        p_Full_o;
  logic        p_NearFull_o;
  logic        p_Empty_o;
  logic        p_Over_o;
  logic [4:0]  Level_o;
  logic        p_Busy_o;
  logic        p_SendFinished_o;
  logic        Tx_o;

  int checks;
  int failures;

  uart_tx_param dut (
    .clk              (clk),
    .rst              (rst),
    .p_Enable_i       (p_Enable_i),
    .Data_i           (Data_i),
    .n_We_i           (n_We_i),
    .n_Clr_i          (n_Clr_i),
    .Divisor_i        (Divisor_i),
    .RoundUpNum_i     (RoundUpNum_i),
    .RoundDownNum_i   (RoundDownNum_i),
    .p_ParityEnable_i (p_ParityEnable_i),
    .ParityMethod_i   (ParityMethod_i),
    .p_BigEnd_i       (p_BigEnd_i),
    .StopBits_i       (StopBits_i),
`ifdef UART_TX_BREAK_EN
    .p_Break_i        (p_Break_i),
`endif
    .p_Full_o         (p_Full_o),
    .p_NearFull_o     (p_NearFull_o),
    .p_Empty_o        (p_Empty_o),
    .p_Over_o         (p_Over_o),
    .Level_o          (Level_o),
    .p_Busy_o         (p_Busy_o),
    .p_SendFinished_o (p_SendFinished_o),
    .Tx_o             (Tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n cycles of Tx_o at a fixed level
  task automatic expect_seg(input string tag, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {31'b0, Tx_o}, {31'b0, lvl});
    end
  endtask

  // Step until the engine leaves IDLE (LOAD cycle), bounded.
  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (!p_Busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_load_seen"}, {31'b0, p_Busy_o}, 32'd1);
    check({tag, "_load_tx"}, {31'b0, Tx_o}, 32'd1);
  endtask

  // Cycle after the last stop clock: pulse, idle, line high; then pulse gone.
  task automatic expect_fin(input string tag);
    @(negedge clk);
    check({tag, "_fin"}, {31'b0, p_SendFinished_o}, 32'd1);
    check({tag, "_fin_idle"}, {31'b0, p_Busy_o}, 32'd0);
    check({tag, "_fin_tx"}, {31'b0, Tx_o}, 32'd1);
    @(negedge clk);
    check({tag, "_fin_drop"}, {31'b0, p_SendFinished_o}, 32'd0);
  endtask

  task automatic push(input logic [7:0] d);
    n_We_i = 1'b0;
    Data_i = d;
    @(negedge clk);
    n_We_i = 1'b1;
  endtask

  logic [7:0] seq;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    p_Enable_i = 1'b0;
    Data_i = 8'h00;
    n_We_i = 1'b1;
    n_Clr_i = 1'b1;
    Divisor_i = 12'd4;
    RoundUpNum_i = 4'd0;
    RoundDownNum_i = 4'd0;
    p_ParityEnable_i = 1'b0;
    ParityMethod_i = 1'b0;
    p_BigEnd_i = 1'b0;
    StopBits_i = 1'b0;
`ifdef UART_TX_BREAK_EN
    p_Break_i = 1'b0;
`endif

    // ---- reset state ----
    @(negedge clk);
    check("rst_tx", {31'b0, Tx_o}, 32'd1);
    check("rst_level", {27'b0, Level_o}, 32'd0);
    check("rst_empty", {31'b0, p_Empty_o}, 32'd1);
    check("rst_full", {31'b0, p_Full_o}, 32'd0);
    check("rst_nearfull", {31'b0, p_NearFull_o}, 32'd0);
    check("rst_over", {31'b0, p_Over_o}, 32'd0);
    check("rst_busy", {31'b0, p_Busy_o}, 32'd0);
    check("rst_fin", {31'b0, p_SendFinished_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // ---- T1: 0xA5, div 4, LSB first, no parity, 1 stop ----
    push(8'hA5);
    check("t1_level", {27'b0, Level_o}, 32'd1);
    check("t1_empty", {31'b0, p_Empty_o}, 32'd0);
    p_Enable_i = 1'b1;
    wait_load("t1");
    expect_seg("t1_start", 1'b0, 4);
    seq = 8'b1010_0101;            // line order, first bit on the left
    for (int i = 0; i < 8; i++) expect_seg("t1_data", seq[7-i], 4);
    expect_seg("t1_stop", 1'b1, 4);
    expect_fin("t1");

    // ---- T2: compensation U=1 D=2, 0x00 -> 5,4,4,5,4,4,5,4,4,5 ----
    RoundUpNum_i = 4'd1;
    RoundDownNum_i = 4'd2;
    push(8'h00);
    wait_load("t2");
    expect_seg("t2_low", 1'b0, 39);   // start(5) + data 4+4+5+4+4+5+4+4
    expect_seg("t2_stop", 1'b1, 5);
    expect_fin("t2");

    // ---- T3: odd parity, MSB first, 2 stop, 0x03; config changed mid-frame ----
    RoundUpNum_i = 4'd0;
    RoundDownNum_i = 4'd0;
    p_ParityEnable_i = 1'b1;
    ParityMethod_i = 1'b1;
    p_BigEnd_i = 1'b1;
    StopBits_i = 1'b1;
    push(8'h03);
    wait_load("t3");
    expect_seg("t3_start", 1'b0, 1);
    Divisor_i = 12'd9;
    p_ParityEnable_i = 1'b0;
    p_BigEnd_i = 1'b0;
    StopBits_i = 1'b0;
    expect_seg("t3_start", 1'b0, 3);
    expect_seg("t3_data0", 1'b0, 24);
    expect_seg("t3_data1", 1'b1, 8);
    expect_seg("t3_parity", 1'b1, 4);
    expect_seg("t3_stop2", 1'b1, 8);
    expect_fin("t3");

    // ---- T4: divisor 0 clamps to 2 clocks per bit, 0xFF ----
    Divisor_i = 12'd0;
    push(8'hFF);
    wait_load("t4");
    expect_seg("t4_start", 1'b0, 2);
    expect_seg("t4_high", 1'b1, 18);
    expect_fin("t4");

    // ---- T5: FIFO fill, overflow, flush ----
    Divisor_i = 12'd4;
    p_Enable_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      n_We_i = 1'b0;
      Data_i = 8'(i);
      @(negedge clk);
      if (i == 10) check("t5_nf_11", {31'b0, p_NearFull_o}, 32'd0);
      if (i == 11) check("t5_nf_12", {31'b0, p_NearFull_o}, 32'd1);
      if (i == 15) check("t5_over_pre", {31'b0, p_Over_o}, 32'd0);
    end
    n_We_i = 1'b1;
    @(negedge clk);
    check("t5_level", {27'b0, Level_o}, 32'd16);
    check("t5_full", {31'b0, p_Full_o}, 32'd1);
    check("t5_over", {31'b0, p_Over_o}, 32'd1);
    check("t5_empty", {31'b0, p_Empty_o}, 32'd0);
    n_Clr_i = 1'b0;
    @(negedge clk);
    n_Clr_i = 1'b1;
    check("t5_clr_level", {27'b0, Level_o}, 32'd0);
    check("t5_clr_empty", {31'b0, p_Empty_o}, 32'd1);
    check("t5_clr_over", {31'b0, p_Over_o}, 32'd0);
    check("t5_clr_full", {31'b0, p_Full_o}, 32'd0);
    n_Clr_i = 1'b0;                  // write during flush is discarded
    n_We_i = 1'b0;
    Data_i = 8'hEE;
    @(negedge clk);
    n_Clr_i = 1'b1;
    n_We_i = 1'b1;
    @(negedge clk);
    check("t5_clr_push", {27'b0, Level_o}, 32'd0);

    // ---- T6: back-to-back frames, push+pop in LOAD, reset mid-frame ----
    push(8'h81);
    push(8'h3C);
    push(8'h5A);
    check("t6_level3", {27'b0, Level_o}, 32'd3);
    p_Enable_i = 1'b1;
    wait_load("t6");
    n_We_i = 1'b0;                   // push in the same cycle as the pop
    Data_i = 8'h77;
    @(negedge clk);
    n_We_i = 1'b1;
    check("t6_pushpop_level", {27'b0, Level_o}, 32'd3);
    check("t6_f1_start", {31'b0, Tx_o}, 32'd0);
    expect_seg("t6_f1_start", 1'b0, 3);
    seq = 8'h81;
    for (int i = 0; i < 8; i++) expect_seg("t6_f1_data", seq[i], 4);
    check("t6_f1_busy", {31'b0, p_Busy_o}, 32'd1);
    expect_seg("t6_f1_stop", 1'b1, 4);
    @(negedge clk);                  // LOAD of frame 2
    check("t6_gap_tx", {31'b0, Tx_o}, 32'd1);
    check("t6_gap_fin", {31'b0, p_SendFinished_o}, 32'd1);
    @(negedge clk);
    check("t6_f2_start", {31'b0, Tx_o}, 32'd0);
    check("t6_f2_fin_drop", {31'b0, p_SendFinished_o}, 32'd0);
    check("t6_f2_level", {27'b0, Level_o}, 32'd2);
    expect_seg("t6_f2_start", 1'b0, 3);
    expect_seg("t6_f2_bit0", 1'b0, 4);
    expect_seg("t6_f2_bit1", 1'b0, 4);
    expect_seg("t6_f2_bit2", 1'b1, 2);
    check("t6_f2_busy", {31'b0, p_Busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_tx", {31'b0, Tx_o}, 32'd1);
    check("t6_rst_level", {27'b0, Level_o}, 32'd0);
    check("t6_rst_busy", {31'b0, p_Busy_o}, 32'd0);
    check("t6_rst_empty", {31'b0, p_Empty_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_post_rst_tx", {31'b0, Tx_o}, 32'd1);

`ifdef UART_TX_BREAK_EN
    // ---- T7: break requested mid-frame ----
    push(8'hF0);
    wait_load("t7");
    expect_seg("t7_start", 1'b0, 2);
    p_Break_i = 1'b1;
    push(8'h0F);
    expect_seg("t7_start", 1'b0, 1);
    expect_seg("t7_data0", 1'b0, 16);
    expect_seg("t7_data1", 1'b1, 16);
    expect_seg("t7_stop", 1'b1, 4);
    @(negedge clk);
    check("t7_fin", {31'b0, p_SendFinished_o}, 32'd1);
    check("t7_brk_tx", {31'b0, Tx_o}, 32'd0);
    check("t7_brk_idle", {31'b0, p_Busy_o}, 32'd0);
    expect_seg("t7_brk_hold", 1'b0, 5);
    check("t7_brk_level", {27'b0, Level_o}, 32'd1);
    p_Break_i = 1'b0;
    @(negedge clk);
    check("t7_rel_tx", {31'b0, Tx_o}, 32'd1);
    check("t7_rel_load", {31'b0, p_Busy_o}, 32'd1);
    @(negedge clk);
    check("t7_rel_start", {31'b0, Tx_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
